// File: rtl/sd_adc_pkg.sv
// Shared constants for the delta-sigma audio path (ADC receive side and DAC side).
package sd_adc_pkg;

    localparam int DECIM_DEF = 7000;
    localparam int SCALE_DEF = 2397;
    localparam int CNT_W_DEF = 13;
    localparam int SAMPLE_W  = 8;

    // Excess-128 midscale code, identical to the DAC input coding.
    localparam logic [SAMPLE_W-1:0] MIDSCALE = 8'h80;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous board input.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/sd_adc_rx.sv
// Delta-sigma receiver: comparator feedback loop, sinc1 ones counter, scaling to an
// unsigned 8-bit sample and a valid/ready output port with a sticky overrun flag.
module sd_adc_rx
    import sd_adc_pkg::*;
#(
    parameter int DECIM = DECIM_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int SCALE = SCALE_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                comp_in,
    output logic                fb_out,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                overrun,
    input  logic                overrun_clr
);

    localparam int PROD_W = CNT_W + 12;

    logic                bit_s;
    logic                fb_q;
    logic [CNT_W-1:0]    win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]    ones_q, ones_d;
    logic [CNT_W-1:0]    hold_q, hold_d;
    logic                load_p_q, load_p_d;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic                load_s_q, load_s_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;
    logic [PROD_W-1:0]   scaled;
    logic                overwrite;

    sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (comp_in),
        .q_o   (bit_s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fb_q      <= 1'b0;
            win_cnt_q <= '0;
            ones_q    <= '0;
            hold_q    <= '0;
            load_p_q  <= 1'b0;
            prod_q    <= '0;
            load_s_q  <= 1'b0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            fb_q      <= bit_s;
            win_cnt_q <= win_cnt_d;
            ones_q    <= ones_d;
            hold_q    <= hold_d;
            load_p_q  <= load_p_d;
            prod_q    <= prod_d;
            load_s_q  <= load_s_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        win_cnt_d = win_cnt_q + CNT_W'(1);
        ones_d    = ones_q + CNT_W'(bit_s);
        hold_d    = hold_q;
        load_p_d  = 1'b0;
        prod_d    = prod_q;
        load_s_d  = load_p_q;
        sample_d  = sample_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        overwrite = 1'b0;
        scaled    = prod_q >> 16;

        // The last bit of the window goes straight into hold rather than through ones.
        if (win_cnt_q == CNT_W'(DECIM - 1)) begin
            hold_d    = ones_q + CNT_W'(bit_s);
            ones_d    = '0;
            win_cnt_d = '0;
            load_p_d  = 1'b1;
        end

        if (load_p_q) begin
            prod_d = PROD_W'(hold_q) * PROD_W'(SCALE);
        end

        // Only a full-scale count scales to 256, which saturates to the top code.
        if (load_s_q) begin
            sample_d  = (scaled > PROD_W'(255)) ? 8'hFF : scaled[7:0];
            valid_d   = 1'b1;
            overwrite = valid_q && !sample_ready;
        end else if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end

        if (overwrite) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    assign fb_out       = fb_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;

endmodule
